// File: rtl/matrix_pkg.sv
// Shared geometry, scan states and row-slice helper for the LED matrix scanner.
package matrix_pkg;

  localparam int unsigned MATRIX_COLUMNS = 5;
  localparam int unsigned MATRIX_ROWS    = 7;
  localparam int unsigned FRAME_BITS     = MATRIX_COLUMNS * MATRIX_ROWS;
  localparam int unsigned COL_BITS       = 3;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    BLANK
  } scan_state_t;

  // Row pattern for one column; bit r set means row r lit.
  function automatic logic [MATRIX_ROWS-1:0] row_slice(
    input logic [FRAME_BITS-1:0] frame,
    input logic [COL_BITS-1:0]   col
  );
    logic [MATRIX_ROWS-1:0] rows;
    rows = '0;
    for (int unsigned c = 0; c < MATRIX_COLUMNS; c++) begin
      if (col == COL_BITS'(c)) rows = frame[c*MATRIX_ROWS +: MATRIX_ROWS];
    end
    return rows;
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter shared by the dwell and blank phases; done flags terminal count.
module scan_timer #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // Load takes priority; otherwise count down and rest at zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/matrix_scan_controller.sv
// Column-multiplexed scan sequencer for the 5x7 LED matrix with double-buffered frames.
module matrix_scan_controller
  import matrix_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [FRAME_BITS-1:0]  frame_data,
  input  logic                   frame_valid,
  output logic                   frame_ready,
  output logic [MATRIX_COLUMNS-1:0] matrix_col,
  output logic [MATRIX_ROWS-1:0] matrix_row,
  output logic [COL_BITS-1:0]    active_column,
  output logic                   frame_start
);

  localparam int unsigned MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_BITS   = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_BITS-1:0] DWELL_LOAD = CNT_BITS'(DWELL_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] BLANK_LOAD = CNT_BITS'(BLANK_CYCLES - 1);
  localparam logic [COL_BITS-1:0] LAST_COL   = COL_BITS'(MATRIX_COLUMNS - 1);

  scan_state_t           state_q, state_d;
  logic [COL_BITS-1:0]   col_q, col_d;
  logic [FRAME_BITS-1:0] display_q, display_d;
  logic [FRAME_BITS-1:0] pending_q, pending_d;
  logic                  full_q, full_d;
  logic                  swap;
  logic                  accept;
  logic                  load;
  logic [CNT_BITS-1:0]   load_value;
  logic                  done;

  scan_timer #(
    .WIDTH (CNT_BITS)
  ) u_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (load),
    .load_value (load_value),
    .done       (done)
  );

  // Sequencing: every state change reloads the timer, so it never wraps.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    load       = 1'b0;
    load_value = '0;
    swap       = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      col_d   = '0;
      load    = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d    = DRIVE;
          col_d      = '0;
          load       = 1'b1;
          load_value = DWELL_LOAD;
          swap       = 1'b1;
        end
        DRIVE: begin
          if (done) begin
            state_d    = BLANK;
            load       = 1'b1;
            load_value = BLANK_LOAD;
          end
        end
        BLANK: begin
          if (done) begin
            state_d    = DRIVE;
            load       = 1'b1;
            load_value = DWELL_LOAD;
            if (col_q == LAST_COL) begin
              col_d = '0;
              swap  = 1'b1;
            end else begin
              col_d = col_q + COL_BITS'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          col_d   = '0;
          load    = 1'b1;
        end
      endcase
    end
  end

  // Double buffer: on a swap edge the pending slot empties into display, so a frame
  // offered on that same edge is taken even though frame_ready showed full.
  always_comb begin
    accept    = frame_valid && (!full_q || swap);
    display_d = (swap && full_q) ? pending_q : display_q;
    pending_d = accept ? frame_data : pending_q;
    if (accept) begin
      full_d = 1'b1;
    end else if (swap) begin
      full_d = 1'b0;
    end else begin
      full_d = full_q;
    end
  end

  // State, column and frame buffer registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      col_q     <= '0;
      display_q <= '0;
      pending_q <= '0;
      full_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      display_q <= display_d;
      pending_q <= pending_d;
      full_q    <= full_d;
    end
  end

  // Pin drive registered from next-state values so pins line up with the new state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      matrix_col    <= '0;
      matrix_row    <= '1;
      active_column <= '0;
      frame_start   <= 1'b0;
    end else begin
      if (state_d == DRIVE) begin
        matrix_col <= MATRIX_COLUMNS'(1) << col_d;
        matrix_row <= ~row_slice(display_d, col_d);
      end else begin
        matrix_col <= '0;
        matrix_row <= '1;
      end
      active_column <= col_d;
      frame_start   <= (state_d == DRIVE) && (state_q != DRIVE) && (col_d == '0);
    end
  end

  assign frame_ready = ~full_q;

endmodule

// File: tb/tb_matrix_scan_controller.sv
// Self-checking bench for matrix_scan_controller with DWELL_CYCLES=4, BLANK_CYCLES=1.
module tb_matrix_scan_controller;

  localparam int unsigned D    = 4;
  localparam int unsigned B    = 1;
  localparam int unsigned SLOT = D + B;
  localparam int unsigned P    = 5 * SLOT;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [34:0] frame_data;
  logic        frame_valid;
  logic        frame_ready;
  logic [4:0]  matrix_col;
  logic [6:0]  matrix_row;
  logic [2:0]  active_column;
  logic        frame_start;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  // Frame-level model: running flag, position within the frame period, two buffers.
  bit          m_run;
  int          m_pos;
  logic [34:0] m_disp;
  logic [34:0] m_pend;
  bit          m_full;

  localparam logic [34:0] FA = {7'h40, 7'h00, 7'h00, 7'h00, 7'h01};
  localparam logic [34:0] F1 = {7'h11, 7'h22, 7'h33, 7'h44, 7'h55};
  localparam logic [34:0] F2 = {7'h0F, 7'h70, 7'h2A, 7'h15, 7'h7F};
  localparam logic [34:0] F3 = {7'h00, 7'h00, 7'h00, 7'h00, 7'h5A};

  matrix_scan_controller #(
    .DWELL_CYCLES (D),
    .BLANK_CYCLES (B)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .enable        (enable),
    .frame_data    (frame_data),
    .frame_valid   (frame_valid),
    .frame_ready   (frame_ready),
    .matrix_col    (matrix_col),
    .matrix_row    (matrix_row),
    .active_column (active_column),
    .frame_start   (frame_start)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic wait_fs();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick(1);
      if (frame_start) seen = 1'b1;
    end
    check("frame_start_seen", seen, 1);
  endtask

  // Model step: advance scan position, swap at column-0 entry, then accept.
  always @(posedge clock or negedge reset_n) begin : model_step
    int np;
    bit nrun;
    bit sw;
    bit acc;
    if (!reset_n) begin
      m_run  <= 1'b0;
      m_pos  <= 0;
      m_disp <= '0;
      m_pend <= '0;
      m_full <= 1'b0;
    end else begin
      sw   = 1'b0;
      np   = m_pos;
      nrun = m_run;
      if (!enable) begin
        nrun = 1'b0;
        np   = 0;
      end else if (!m_run) begin
        nrun = 1'b1;
        np   = 0;
        sw   = 1'b1;
      end else begin
        np = (m_pos + 1) % P;
        sw = (np == 0);
      end
      acc = frame_valid && (!m_full || sw);
      m_run <= nrun;
      m_pos <= np;
      if (sw && m_full) m_disp <= m_pend;
      if (acc) m_pend <= frame_data;
      m_full <= acc ? 1'b1 : (sw ? 1'b0 : m_full);
    end
  end

  // Per-cycle compare of every output against the model, on the falling edge.
  always @(negedge clock) begin : compare
    int          c;
    logic [4:0]  ec;
    logic [6:0]  er;
    logic [2:0]  ea;
    logic        ef;
    logic [34:0] sh;
    if (chk_on) begin
      ec = '0;
      er = 7'h7F;
      ea = '0;
      ef = 1'b0;
      if (m_run) begin
        c  = m_pos / SLOT;
        ea = 3'(c);
        ef = (m_pos == 0);
        if ((m_pos % SLOT) < D) begin
          ec = 5'(1 << c);
          sh = m_disp >> (7 * c);
          er = ~sh[6:0];
        end
      end
      check("cyc_col", matrix_col, ec);
      check("cyc_row", matrix_row, er);
      check("cyc_active", active_column, ea);
      check("cyc_fstart", frame_start, ef);
      check("cyc_ready", frame_ready, !m_full);
    end
  end

  initial begin
    int first_fs;
    reset_n     = 1'b0;
    enable      = 1'b0;
    frame_valid = 1'b0;
    frame_data  = '0;
    tick(2);
    chk_on = 1'b1;
    check("rst_col", matrix_col, 5'h00);
    check("rst_row", matrix_row, 7'h7F);
    check("rst_active", active_column, 3'd0);
    check("rst_fstart", frame_start, 1'b0);
    check("rst_ready", frame_ready, 1'b1);

    // Free-running scan with an empty display.
    reset_n  = 1'b1;
    enable   = 1'b1;
    first_fs = -1;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (frame_start && first_fs < 0) first_fs = i;
      if (first_fs >= 0) begin
        case (i - first_fs)
          0:  check("scan_off0_col", matrix_col, 5'h01);
          4:  check("scan_off4_col", matrix_col, 5'h00);
          5:  check("scan_off5_col", matrix_col, 5'h02);
          20: check("scan_off20_col", matrix_col, 5'h10);
          24: check("scan_off24_col", matrix_col, 5'h00);
          25: check("scan_period_fs", frame_start, 1'b1);
          default: ;
        endcase
      end
    end
    check("scan_first_fs", first_fs, 0);

    // Single frame: column 0 row 0, column 4 row 6.
    frame_data  = FA;
    frame_valid = 1'b1;
    tick(1);
    frame_valid = 1'b0;
    check("fa_ready_low", frame_ready, 1'b0);
    wait_fs();
    check("fa_col0", matrix_col, 5'h01);
    check("fa_row0", matrix_row, 7'h7E);
    check("fa_ready_back", frame_ready, 1'b1);
    tick(20);
    check("fa_col4", matrix_col, 5'h10);
    check("fa_row4", matrix_row, 7'h3F);

    // Back-to-back frames; second held on valid through the swap edge.
    tick(2);
    frame_data  = F1;
    frame_valid = 1'b1;
    tick(1);
    frame_data = F2;
    check("bb_ready_low", frame_ready, 1'b0);
    wait_fs();
    frame_valid = 1'b0;
    check("bb_f1_row0", matrix_row, 7'h2A);
    check("bb_ready_held", frame_ready, 1'b0);
    wait_fs();
    check("bb_f2_row0", matrix_row, 7'h00);
    check("bb_ready_free", frame_ready, 1'b1);

    // Enable drop in column 2, accept while idle, re-enable.
    tick(11);
    check("en_col2_active", active_column, 3'd2);
    check("en_col2_col", matrix_col, 5'h04);
    enable = 1'b0;
    tick(1);
    check("idle_col", matrix_col, 5'h00);
    check("idle_row", matrix_row, 7'h7F);
    check("idle_active", active_column, 3'd0);
    frame_data  = F3;
    frame_valid = 1'b1;
    tick(1);
    frame_valid = 1'b0;
    check("idle_accept", frame_ready, 1'b0);
    enable = 1'b1;
    tick(1);
    check("reen_col", matrix_col, 5'h01);
    check("reen_fs", frame_start, 1'b1);
    check("reen_row", matrix_row, 7'h25);
    check("reen_ready", frame_ready, 1'b1);

    // Asynchronous reset between edges during DRIVE.
    tick(2);
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_col", matrix_col, 5'h00);
    check("arst_row", matrix_row, 7'h7F);
    check("arst_active", active_column, 3'd0);
    check("arst_ready", frame_ready, 1'b1);
    tick(2);
    reset_n = 1'b1;
    tick(1);
    check("post_rst_col", matrix_col, 5'h01);
    check("post_rst_row", matrix_row, 7'h7F);
    check("post_rst_fs", frame_start, 1'b1);
    tick(30);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
